// File: rtl/cmac_acc_pkg.sv
// cmac_acc_pkg
// Shared definitions for the CMAC product accumulator slice.
//   ACC_W_DEFAULT / OUT_W_DEFAULT / CNT_W_DEFAULT : default widths of the
//       internal accumulator, the emitted sum and the beat counter.
//   PROD_NEG_ZERO : the multiplier's signed-zero encoding, which must be
//       accumulated as 0.
//   acc_state_e   : stage-2 state (no partial sum / partial sum held).
package cmac_acc_pkg;

    localparam int ACC_W_DEFAULT = 48;
    localparam int OUT_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 16;

    localparam logic [31:0] PROD_NEG_ZERO = 32'h8000_0000;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/cmac_prod_accum_if.sv
// cmac_prod_accum_if
// Groups the product-input and sum-output handshakes of the accumulator.
//   in_valid/in_ready/in_prod/in_last : product beats from the multiplier
//   clr                               : synchronous abort of the partial group
//   out_valid/out_ready               : result handshake to the consumer
//   out_sum/out_sat/out_count         : saturated sum, clamp flag, beat count
// Modports:
//   master : the side that produces beats and consumes results
//   slave  : the accumulator itself
interface cmac_prod_accum_if
    import cmac_acc_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_prod;
    logic             in_last;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_sum;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_prod, in_last, clr, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_prod, in_last, clr, out_ready,
        output in_ready, out_valid, out_sum, out_sat, out_count
    );

endinterface

// File: rtl/cmac_acc_sat.sv
// cmac_acc_sat
// Combinational clamp of a two's-complement ACC_W-bit value into OUT_W bits.
//   sum_in  : ACC_W-bit signed value
//   sum_out : OUT_W-bit value, clamped to the representable range
//   sat     : high when sum_out differs from sum_in (clamping happened)
module cmac_acc_sat
    import cmac_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int OUT_W = OUT_W_DEFAULT
) (
    input  logic [ACC_W-1:0] sum_in,
    output logic [OUT_W-1:0] sum_out,
    output logic             sat
);

    // The value fits in OUT_W bits exactly when every bit from the OUT_W
    // sign position upwards is a copy of the sign.
    logic [ACC_W-OUT_W:0] upper;

    assign upper = sum_in[ACC_W-1:OUT_W-1];
    assign sat   = !((&upper) || (~|upper));

    // Out of range: pick the extreme on the side of the true sign.
    always_comb begin
        sum_out = sum_in[OUT_W-1:0];
        if (sat) begin
            sum_out = sum_in[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/cmac_prod_accum.sv
// cmac_prod_accum
// Accumulates signed 32-bit multiplier products into per-group sums and
// emits one saturated OUT_W-bit sum plus beat count per group.
//   nvdla_core_clk : core clock, rising edge
//   nvdla_core_rst : asynchronous active-high reset
//   bus            : cmac_prod_accum_if slave (beat input, clr, result output)
// Pipeline: stage 1 registers the sign-extended beat, stage 2 adds it to the
// running sum and, on the last beat, loads the result register.
module cmac_prod_accum
    import cmac_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int OUT_W = OUT_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    cmac_prod_accum_if.slave  bus
);

    logic             v_s1;
    logic             last_s1;
    logic [ACC_W-1:0] prod_s1;
    logic [ACC_W-1:0] prod_ext;

    acc_state_e       state;
    acc_state_e       state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_fin;
    logic [OUT_W-1:0] sat_val;
    logic             sat_flag;

    logic             stall;
    logic             take_s1;
    logic             load_res;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_sum_q;
    logic             out_sat_q;
    logic [CNT_W-1:0] out_count_q;

    // A last beat cannot leave stage 1 while the result register is still
    // occupied and not being drained this cycle.
    assign stall   = v_s1 && last_s1 && out_valid_q && !bus.out_ready;
    assign take_s1 = v_s1 && !stall && !bus.clr;

    assign bus.in_ready  = !stall && !bus.clr;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_count = out_count_q;

    // The signed-zero code would otherwise contribute -2^31.
    assign prod_ext = (bus.in_prod == PROD_NEG_ZERO)
                    ? '0
                    : {{(ACC_W-32){bus.in_prod[31]}}, bus.in_prod};

    // A new group starts from zero regardless of stale acc contents.
    assign base    = (state == ACC_IDLE) ? '0 : acc;
    assign sum     = base + prod_s1;
    assign cnt_fin = (state == ACC_IDLE) ? CNT_W'(1)
                   : ((&cnt) ? cnt : cnt + CNT_W'(1));

    cmac_acc_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .sum_in  (sum),
        .sum_out (sat_val),
        .sat     (sat_flag)
    );

    // Stage 1: capture an accepted beat; hold it during a stall; clr drops it.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            v_s1    <= 1'b0;
            last_s1 <= 1'b0;
            prod_s1 <= '0;
        end else if (bus.clr) begin
            v_s1    <= 1'b0;
        end else if (!stall) begin
            v_s1 <= bus.in_valid;
            if (bus.in_valid) begin
                last_s1 <= bus.in_last;
                prod_s1 <= prod_ext;
            end
        end
    end

    // Stage 2 state register: running sum, beat count and group state.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= ACC_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stage 2 next state: clr aborts the group; a non-last beat extends it;
    // a last beat closes it and hands the total to the result register.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        load_res  = 1'b0;
        if (bus.clr) begin
            state_nxt = ACC_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else if (take_s1) begin
            if (last_s1) begin
                load_res  = 1'b1;
                state_nxt = ACC_IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
            end else begin
                state_nxt = ACC_RUN;
                acc_nxt   = sum;
                cnt_nxt   = cnt_fin;
            end
        end
    end

    // Result register: a fresh load wins over consumption in the same cycle,
    // which gives back-to-back results without a bubble.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else if (load_res) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sat_val;
            out_sat_q   <= sat_flag;
            out_count_q <= cnt_fin;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmac_prod_accum.sv
// tb_cmac_prod_accum
// Directed and randomized stimulus for cmac_prod_accum. A transaction-level
// model collects accepted beats into groups with plain integer arithmetic and
// queues the expected (sum, sat, count) per group; every consumed result is
// compared against the head of that queue.
module tb_cmac_prod_accum;
    import cmac_acc_pkg::*;

    localparam int ACC_W   = 48;
    localparam int OUT_W   = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam longint OUT_MAX = 64'sd2147483647;
    localparam longint OUT_MIN = -OUT_MAX - 64'sd1;

    typedef struct {
        logic [31:0] sum;
        logic        sat;
        int          count;
    } result_t;

    logic nvdla_core_clk = 1'b0;
    logic nvdla_core_rst = 1'b1;

    cmac_prod_accum_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    cmac_prod_accum #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .bus            (bus)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    int      n_checks = 0;
    int      n_pass   = 0;
    result_t exp_q[$];
    longint  grp_sum  = 0;
    int      grp_n    = 0;
    logic    prev_ready    = 1'b0;
    logic    prev_last_acc = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint beatValue(input logic [31:0] p);
        return (p == PROD_NEG_ZERO) ? 64'sd0 : longint'($signed(p));
    endfunction

    task automatic closeGroup();
        result_t r;
        if (grp_sum > OUT_MAX) begin
            r.sum = 32'h7FFF_FFFF;
            r.sat = 1'b1;
        end else if (grp_sum < OUT_MIN) begin
            r.sum = 32'h8000_0000;
            r.sat = 1'b1;
        end else begin
            r.sum = grp_sum[31:0];
            r.sat = 1'b0;
        end
        r.count = (grp_n > CNT_MAX) ? CNT_MAX : grp_n;
        exp_q.push_back(r);
        grp_sum = 0;
        grp_n   = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, then check any
    // consumed result and account for an accepted beat in the model.
    task automatic applyStimulus(input logic v, input logic [31:0] p, input logic l,
                                 input logic c, input logic ordy);
        logic    acc_now;
        result_t r;
        @(negedge nvdla_core_clk);
        bus.in_valid  = v;
        bus.in_prod   = p;
        bus.in_last   = l;
        bus.clr       = c;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_extra_result", 64'(exp_q.size()), 64'd1);
            end else begin
                r = exp_q.pop_front();
                checkOutput("sb_sum",   64'(bus.out_sum),   64'(r.sum));
                checkOutput("sb_sat",   64'(bus.out_sat),   64'(r.sat));
                checkOutput("sb_count", 64'(bus.out_count), 64'(r.count));
            end
        end
        acc_now = v && !c && bus.in_ready;
        if (c) begin
            grp_sum = 0;
            grp_n   = 0;
        end
        if (acc_now) begin
            grp_sum += beatValue(p);
            grp_n++;
            if (l) closeGroup();
        end
        prev_ready    = bus.in_ready;
        prev_last_acc = acc_now && l;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.clr       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values.
        #12;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_sum",   64'(bus.out_sum),   64'd0);
        checkOutput("rst_out_sat",   64'(bus.out_sat),   64'd0);
        checkOutput("rst_out_count", 64'(bus.out_count), 64'd0);
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic group with T+2 latency.
        applyStimulus(1'b1, 32'd100,        1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFCE,  1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd7,          1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0000,  1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_t1_valid", 64'(bus.out_valid), 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_t2_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("basic_sum",      64'(bus.out_sum),   64'd57);
        checkOutput("basic_count",    64'(bus.out_count), 64'd4);
        checkOutput("basic_sat",      64'(bus.out_sat),   64'd0);

        // Positive and negative saturation.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h4000_0000, (i == 2), 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("satpos_sum", 64'(bus.out_sum), 64'h7FFF_FFFF);
        checkOutput("satpos_sat", 64'(bus.out_sat), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC000_0000, (i == 2), 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("satneg_sum", 64'(bus.out_sum), 64'h8000_0000);
        checkOutput("satneg_sat", 64'(bus.out_sat), 64'd1);

        // Backpressure: {1,2 last} and {3 last} with out_ready low.
        applyStimulus(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_accept3_ready", 64'(bus.in_ready), 64'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("bp_hold_sum",   64'(bus.out_sum),   64'd3);
        checkOutput("bp_hold_count", 64'(bus.out_count), 64'd2);
        checkOutput("bp_stall_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_stall_ready2", 64'(bus.in_ready), 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_first_count", 64'(bus.out_count), 64'd2);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_second_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("bp_second_sum",   64'(bus.out_sum),   64'd3);
        checkOutput("bp_second_count", 64'(bus.out_count), 64'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_drained_valid", 64'(bus.out_valid), 64'd0);

        // clr mid-group.
        applyStimulus(1'b1, 32'd10, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd20, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd99, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_in_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(1'b1, 32'd5, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_sum",   64'(bus.out_sum),   64'd5);
        checkOutput("clr_count", 64'(bus.out_count), 64'd1);

        // Count boundary: 2^CNT_W beats leave the count at all-ones.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'd1, (i == 15), 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("cntsat_count", 64'(bus.out_count), 64'(CNT_MAX));
        checkOutput("cntsat_sum",   64'(bus.out_sum),   64'd16);

        // Reset with a held result and a partial sum.
        applyStimulus(1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("prerst_valid", 64'(bus.out_valid), 64'd1);
        nvdla_core_rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midrst_sum",   64'(bus.out_sum),   64'd0);
        checkOutput("midrst_count", 64'(bus.out_count), 64'd0);
        exp_q.delete();
        grp_sum = 0;
        grp_n   = 0;
        @(negedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b0;
        #1;
        checkOutput("postrst_ready", 64'(bus.in_ready), 64'd1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("postrst_sum",   64'(bus.out_sum),   64'hFFFF_FFFF);
        checkOutput("postrst_count", 64'(bus.out_count), 64'd1);

        // Single-cycle turnaround: one-beat groups back to back.
        applyStimulus(1'b1, 32'd1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd3, 1'b1, 1'b0, 1'b1);
        checkOutput("turn1_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("turn1_sum",   64'(bus.out_sum),   64'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("turn2_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("turn2_sum",   64'(bus.out_sum),   64'd2);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("turn3_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("turn3_sum",   64'(bus.out_sum),   64'd3);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic; clr only where no closed group is still in flight.
        for (int i = 0; i < 500; i++) begin
            logic        v;
            logic        l;
            logic        c;
            logic        o;
            logic [31:0] p;
            int          sel;
            v   = ($urandom_range(3) != 0);
            sel = $urandom_range(9);
            if (sel == 0)      p = PROD_NEG_ZERO;
            else if (sel == 1) p = 32'h7000_0000 | ($urandom & 32'h0FFF_FFFF);
            else if (sel == 2) p = 32'h9000_0000 | ($urandom & 32'h0FFF_FFFF);
            else               p = 32'($urandom_range(2000)) - 32'd1000;
            l = ($urandom_range(7) == 0);
            c = prev_ready && !prev_last_acc && ($urandom_range(29) == 0);
            o = ($urandom_range(2) != 0);
            applyStimulus(v, p, l, c, o);
        end

        // Drain outstanding results with a bounded wait.
        for (int g = 0; g < 100 && exp_q.size() != 0; g++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
